digit_scan_dec: RTL and testbench

Parametrised multiplexed-display digit scanner: the sequential successor to the fixed 2-to-4 one-hot decoder.
- Cycles a binary select over NUM_DIGITS positions at a prescaled rate.
- Drives the matching one-hot anode line, with per-digit blanking and a dead-time guard against ghosting between digits.
- Sits between the alarm/clock time registers (which consume sel_o to mux BCD digits) and the 7-segment anode pins.

---
 rtl/digit_scan_pkg.sv | 33 +++
 rtl/digit_scan_dec_onehot.sv | 21 ++
 rtl/digit_scan_dec.sv | 178 +++++++++++++++++
 tb/tb_digit_scan_dec.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared types and helpers for the multiplexed-display digit scanner.
// Optional blink feature is controlled by the macro DIGIT_SCAN_BLINK_EN
// (see digit_scan_dec.sv).
package digit_scan_pkg;

    // Scanner states: idle (all dark), digit lit, dead time between digits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        GUARD = 2'd2
    } scan_state_t;

    // Ceiling log2 with a floor of 1 so every counter/select has at least one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Anode level meaning "off" for the given polarity, in the low 'width' bits.
    function automatic logic [15:0] inactive_level(input bit active_low, input int width);
        int ones;
        ones = (1 << width) - 1;
        return active_low ? 16'(ones) : 16'd0;
    endfunction

endpackage

// File: rtl/digit_scan_dec_onehot.sv
// Parametrised binary-to-one-hot decoder with enable; out-of-range index
// decodes to all zeros.
module dec_onehot
    import digit_scan_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = clog2_min1(NUM_OUT)
) (
    input  logic               en,
    input  logic [SEL_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
            // One comparator per output line; indices >= NUM_OUT match nothing.
            assign onehot[gi] = en && (idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/digit_scan_dec.sv
// Multiplexed 7-segment digit scanner: cycles a select over NUM_DIGITS
// positions at a prescaled rate, drives the matching anode with per-digit
// blanking and a dead-time guard between digits. All outputs registered.
// Optional feature macro: DIGIT_SCAN_BLINK_EN adds blink_mask / BLINK_FRAMES.
module digit_scan_dec
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SEL_W        = clog2_min1(NUM_DIGITS),
    parameter int PRESCALE     = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
`ifdef DIGIT_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] blank_mask,
`ifdef DIGIT_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [SEL_W-1:0]      sel_o,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic                  tick_o
);

    localparam int PSC_W = clog2_min1(PRESCALE);
    localparam int GRD_W = clog2_min1((GUARD_CYCLES > 1) ? GUARD_CYCLES : 1);

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    localparam logic [15:0]           INACTIVE_FULL = inactive_level(ACTIVE_LOW, NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] INACTIVE      = INACTIVE_FULL[NUM_DIGITS-1:0];

    scan_state_t state_reg, state_next;
    logic [PSC_W-1:0]      psc_reg, psc_next;
    logic [GRD_W-1:0]      grd_reg, grd_next;
    logic [SEL_W-1:0]      sel_reg, sel_next;
    logic                  tick_reg, tick_next;
    logic [NUM_DIGITS-1:0] anode_reg, anode_next;

    logic [NUM_DIGITS-1:0] dark;
    logic [NUM_DIGITS-1:0] lit_onehot;
    logic [NUM_DIGITS-1:0] active;

    // Next-state, counter and select logic; en=0 forces IDLE but a
    // coincident advance still moves sel and issues the tick.
    always_comb begin
        state_next = state_reg;
        psc_next   = psc_reg;
        grd_next   = grd_reg;
        sel_next   = sel_reg;
        tick_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                psc_next = '0;
                grd_next = '0;
                if (en) begin
                    state_next = ON;
                end
            end
            ON: begin
                if (psc_reg == PSC_LAST) begin
                    psc_next   = '0;
                    grd_next   = '0;
                    tick_next  = 1'b1;
                    sel_next   = (sel_reg == SEL_LAST) ? '0 : sel_reg + SEL_W'(1);
                    state_next = (GUARD_CYCLES > 0) ? GUARD : ON;
                end else begin
                    psc_next = psc_reg + PSC_W'(1);
                end
            end
            GUARD: begin
                if (grd_reg == GRD_LAST) begin
                    grd_next   = '0;
                    psc_next   = '0;
                    state_next = ON;
                end else begin
                    grd_next = grd_reg + GRD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                psc_next   = '0;
                grd_next   = '0;
            end
        endcase

        if (!en) begin
            state_next = IDLE;
            psc_next   = '0;
            grd_next   = '0;
        end
    end

`ifdef DIGIT_SCAN_BLINK_EN
    localparam int BF_W = clog2_min1(BLINK_FRAMES);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] frame_reg, frame_next;
    logic            phase_reg, phase_next;

    // Frame counting on select wrap; phase flips every BLINK_FRAMES frames.
    always_comb begin
        frame_next = frame_reg;
        phase_next = phase_reg;
        if (tick_next && (sel_reg == SEL_LAST)) begin
            if (frame_reg == BF_LAST) begin
                frame_next = '0;
                phase_next = ~phase_reg;
            end else begin
                frame_next = frame_reg + BF_W'(1);
            end
        end
    end

    // Blink counter/phase registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_reg <= '0;
            phase_reg <= 1'b1;
        end else begin
            frame_reg <= frame_next;
            phase_reg <= phase_next;
        end
    end

    // The phase of the upcoming cycle decides blinking, matching sel_next.
    assign dark = blank_mask | (phase_next ? '0 : blink_mask);
`else
    assign dark = blank_mask;
`endif

    dec_onehot #(
        .NUM_OUT (NUM_DIGITS),
        .SEL_W   (SEL_W)
    ) u_dec (
        .en     (state_next == ON),
        .idx    (sel_next),
        .onehot (lit_onehot)
    );

    // Anode is computed from next state/select so anode and sel move together.
    always_comb begin
        active     = lit_onehot & ~dark;
        anode_next = active ^ INACTIVE;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            psc_reg   <= '0;
            grd_reg   <= '0;
            sel_reg   <= '0;
            tick_reg  <= 1'b0;
            anode_reg <= INACTIVE;
        end else begin
            state_reg <= state_next;
            psc_reg   <= psc_next;
            grd_reg   <= grd_next;
            sel_reg   <= sel_next;
            tick_reg  <= tick_next;
            anode_reg <= anode_next;
        end
    end

    assign sel_o   = sel_reg;
    assign anode_o = anode_reg;
    assign tick_o  = tick_reg;

endmodule

// File: tb/tb_digit_scan_dec.sv
// Self-checking bench for digit_scan_dec: table-driven main scan, a 3-digit
// no-guard instance, and (with DIGIT_SCAN_BLINK_EN) a blink instance.
module tb_digit_scan_dec;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] blank;
        logic [1:0] sel;
        logic [3:0] anode;
        logic       tick;
    } vec_t;

    typedef struct {
        string      name;
        int         idx;
        logic [3:0] sel;
        logic [3:0] anode;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 4 digits, PRESCALE 3, GUARD 1, active low.
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] blank = 4'b0;
    logic [1:0] sel;
    logic [3:0] anode;
    logic       tick;

    // 3-digit instance without guard.
    logic       rst3_n = 1'b0;
    logic       en3    = 1'b0;
    logic [1:0] sel3;
    logic [2:0] anode3;
    logic       tick3;

    digit_scan_dec #(
        .NUM_DIGITS(4), .PRESCALE(3), .GUARD_CYCLES(1), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_mask(blank),
`ifdef DIGIT_SCAN_BLINK_EN
        .blink_mask(4'b0000),
`endif
        .sel_o(sel), .anode_o(anode), .tick_o(tick)
    );

    digit_scan_dec #(
        .NUM_DIGITS(3), .PRESCALE(3), .GUARD_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut3 (
        .clk(clk), .rst_n(rst3_n), .en(en3), .blank_mask(3'b000),
`ifdef DIGIT_SCAN_BLINK_EN
        .blink_mask(3'b000),
`endif
        .sel_o(sel3), .anode_o(anode3), .tick_o(tick3)
    );

`ifdef DIGIT_SCAN_BLINK_EN
    logic       rstb_n = 1'b0;
    logic       enb    = 1'b0;
    logic [1:0] selb;
    logic [3:0] anodeb;
    logic       tickb;

    digit_scan_dec #(
        .NUM_DIGITS(4), .PRESCALE(3), .GUARD_CYCLES(1), .ACTIVE_LOW(1'b1),
        .BLINK_FRAMES(2)
    ) dutb (
        .clk(clk), .rst_n(rstb_n), .en(enb), .blank_mask(4'b0000),
        .blink_mask(4'b0001),
        .sel_o(selb), .anode_o(anodeb), .tick_o(tickb)
    );
`endif

    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] expv);
        total = total + 1;
        if (act === expv) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, expv);
        end
    endtask

    task automatic add(input int n, input logic r, input logic e, input logic [3:0] b,
                       input logic [1:0] s, input logic [3:0] a, input logic t);
        vec_t v;
        v.rst_n = r; v.en = e; v.blank = b; v.sel = s; v.anode = a; v.tick = t;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic push_exp(input string name, input int idx, input logic [3:0] s,
                            input logic [3:0] a, input logic t);
        exp_t x;
        x.name = name; x.idx = idx; x.sel = s; x.anode = a; x.tick = t;
        exp_q.push_back(x);
    endtask

    initial begin
        exp_t x;
        int   sidx;
        int   fr;
        logic [3:0] a_exp;

        // Each row: inputs before an edge, expected outputs after it.
        add(1, 0, 0, 4'b0000, 0, 4'b1111, 0);  // reset
        add(3, 1, 1, 4'b0000, 0, 4'b1110, 0);  // digit 0 lit 3 cycles
        add(1, 1, 1, 4'b0000, 1, 4'b1111, 1);  // guard + tick
        add(3, 1, 1, 4'b0000, 1, 4'b1101, 0);
        add(1, 1, 1, 4'b0000, 2, 4'b1111, 1);
        add(3, 1, 1, 4'b0000, 2, 4'b1011, 0);
        add(1, 1, 1, 4'b0000, 3, 4'b1111, 1);
        add(3, 1, 1, 4'b0000, 3, 4'b0111, 0);
        add(1, 1, 1, 4'b0000, 0, 4'b1111, 1);  // wrap to 0
        add(3, 1, 1, 4'b0100, 0, 4'b1110, 0);  // digit 2 blanked this frame
        add(1, 1, 1, 4'b0100, 1, 4'b1111, 1);
        add(3, 1, 1, 4'b0100, 1, 4'b1101, 0);
        add(1, 1, 1, 4'b0100, 2, 4'b1111, 1);
        add(3, 1, 1, 4'b0100, 2, 4'b1111, 0);  // blanked slot, sel still 2
        add(1, 1, 1, 4'b0100, 3, 4'b1111, 1);
        add(1, 1, 1, 4'b0100, 3, 4'b0111, 0);
        add(1, 1, 1, 4'b1000, 3, 4'b1111, 0);  // blank change seen next edge
        add(1, 1, 1, 4'b0000, 3, 4'b0111, 0);
        add(1, 1, 1, 4'b0000, 0, 4'b1111, 1);
        add(3, 1, 1, 4'b0000, 0, 4'b1110, 0);
        add(1, 1, 1, 4'b0000, 1, 4'b1111, 1);
        add(3, 1, 1, 4'b0000, 1, 4'b1101, 0);
        add(1, 1, 1, 4'b0000, 2, 4'b1111, 1);
        add(1, 1, 1, 4'b0000, 2, 4'b1011, 0);
        add(2, 1, 0, 4'b0000, 2, 4'b1111, 0);  // en dropped mid-ON, sel held
        add(3, 1, 1, 4'b0000, 2, 4'b1011, 0);  // full 3-cycle slot on resume
        add(1, 1, 1, 4'b0000, 3, 4'b1111, 1);
        add(3, 1, 1, 4'b0000, 3, 4'b0111, 0);
        add(1, 1, 0, 4'b0000, 0, 4'b1111, 1);  // tick coincides with en fall
        add(1, 1, 0, 4'b0000, 0, 4'b1111, 0);
        add(3, 1, 1, 4'b0000, 0, 4'b1110, 0);
        add(1, 1, 1, 4'b0000, 1, 4'b1111, 1);  // in GUARD
        add(1, 0, 1, 4'b0000, 0, 4'b1111, 0);  // reset during guard
        add(3, 1, 1, 4'b0000, 0, 4'b1110, 0);  // resumes at digit 0
        add(1, 1, 1, 4'b0000, 1, 4'b1111, 1);
        add(1, 1, 1, 4'b0000, 1, 4'b1101, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            blank = vecs[i].blank;
            push_exp("main", i, {2'b00, vecs[i].sel}, vecs[i].anode, vecs[i].tick);
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            check({x.name, "_sel"},   x.idx, {2'b00, sel}, x.sel);
            check({x.name, "_anode"}, x.idx, anode,        x.anode);
            check({x.name, "_tick"},  x.idx, {3'b000, tick}, {3'b000, x.tick});
        end

        // 3 digits, no guard: sel 0,1,2,0..., anode never all dark.
        @(negedge clk);
        rst3_n = 1'b0;
        @(posedge clk);
        #1;
        check("n3_reset_anode", 0, {1'b0, anode3}, 4'b0111);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            rst3_n = 1'b1;
            en3    = 1'b1;
            sidx   = (k / 3) % 3;
            a_exp  = 4'b0111 ^ (4'b0001 << sidx);
            push_exp("n3", k, 4'(sidx), a_exp, (k > 0) && (k % 3 == 0));
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            check({x.name, "_sel"},   x.idx, {2'b00, sel3}, x.sel);
            check({x.name, "_anode"}, x.idx, {1'b0, anode3}, x.anode);
            check({x.name, "_tick"},  x.idx, {3'b000, tick3}, {3'b000, x.tick});
        end

`ifdef DIGIT_SCAN_BLINK_EN
        // Blink: digit 0 lit in frames 0-1, dark 2-3, lit 4-5.
        @(negedge clk);
        rstb_n = 1'b0;
        @(posedge clk);
        #1;
        check("blink_reset_anode", 0, anodeb, 4'b1111);
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            rstb_n = 1'b1;
            enb    = 1'b1;
            sidx   = ((k + 1) / 4) % 4;
            fr     = (k + 1) / 16;
            if (k % 4 == 3) a_exp = 4'b1111;
            else if (sidx == 0 && ((fr / 2) % 2 == 1)) a_exp = 4'b1111;
            else a_exp = 4'b1111 ^ (4'b0001 << sidx);
            push_exp("blink", k, 4'(sidx), a_exp, (k % 4 == 3));
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            check({x.name, "_sel"},   x.idx, {2'b00, selb}, x.sel);
            check({x.name, "_anode"}, x.idx, anodeb, x.anode);
            check({x.name, "_tick"},  x.idx, {3'b000, tickb}, {3'b000, x.tick});
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
